// File: rtl/call_stack.sv
// call_stack: return-address stack built on a circular buffer.
// Optional feature macro: CALL_STACK_GUARD_EN
//   defined   -> a push while full is ignored; sticky overflow/underflow flags are live.
//   undefined -> a push while full overwrites the oldest entry; the flags read 0.
module call_stack #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_WIDTH-1:0]    in_data,
    input  logic                     clear_err,
    output logic [ADDR_WIDTH-1:0]    out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // ptr names the next free slot; the live top sits one slot below it.
    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         top_ptr;
    logic [PW-1:0]         ptr_next;
    logic [CW-1:0]         count_next;
    logic [PW-1:0]         write_addr;
    logic                  write_en;
    logic                  ovf_evt;
    logic                  unf_evt;

    assign top_ptr  = ptr - 1'b1;
    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign out_data = empty ? '0 : mem[top_ptr];

    // Decode push/pop into a buffer write, the next pointer/count and error events.
    always_comb begin
        write_en   = 1'b0;
        write_addr = ptr;
        ptr_next   = ptr;
        count_next = count;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        if (push && pop) begin
            if (empty) begin
                write_en   = 1'b1;
                write_addr = ptr;
                ptr_next   = ptr + 1'b1;
                count_next = count + 1'b1;
                unf_evt    = 1'b1;
            end else begin
                write_en   = 1'b1;
                write_addr = top_ptr;
            end
        end else if (push) begin
            if (!full) begin
                write_en   = 1'b1;
                write_addr = ptr;
                ptr_next   = ptr + 1'b1;
                count_next = count + 1'b1;
            end else begin
`ifdef CALL_STACK_GUARD_EN
                ovf_evt    = 1'b1;
`else
                write_en   = 1'b1;
                write_addr = ptr;
                ptr_next   = ptr + 1'b1;
`endif
            end
        end else if (pop) begin
            if (!empty) begin
                ptr_next   = ptr - 1'b1;
                count_next = count - 1'b1;
            end else begin
                unf_evt    = 1'b1;
            end
        end
    end

    // Pointer and count registers; reset clears them immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else begin
            ptr   <= ptr_next;
            count <= count_next;
        end
    end

    // Buffer storage is never reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (write_en && !reset) begin
            mem[write_addr] <= in_data;
        end
    end

`ifdef CALL_STACK_GUARD_EN
    // Sticky error flags: an event at the edge beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt | (overflow & ~clear_err);
            underflow <= unf_evt | (underflow & ~clear_err);
        end
    end
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{ovf_evt, unf_evt, clear_err};
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
